// File: rtl/pc_redirect_sequencer.sv
// IF-stage PC owner: sequential PC+4 advance, prioritised branch/jump redirects,
// and a one-entry buffer that holds a redirect raised while the hazard unit stalls.
module pc_redirect_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             jmp_valid,
    input  logic [31:0]      jmp_target,
    input  logic             jr_valid,
    input  logic [31:0]      jr_target,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             flush_if,
    output logic             redirect_pend,
    output logic             addr_err,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    localparam logic [1:0] CLS_J  = 2'd0;
    localparam logic [1:0] CLS_JR = 2'd1;
    localparam logic [1:0] CLS_BR = 2'd2;

    state_t             state_reg, state_next;
    logic [31:0]        pc_reg, pc_next;
    logic [31:0]        pend_target_reg, pend_target_next;
    logic [1:0]         pend_class_reg, pend_class_next;
    logic               flush_reg, flush_next;
    logic               err_reg, err_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    logic               req_valid;
    logic [1:0]         req_class;
    logic [31:0]        req_target;
    logic               apply;
    logic [31:0]        apply_target;

    // The older instruction in the pipeline (EX branch) beats the ID-stage jumps.
    always_comb begin
        req_valid  = 1'b1;
        req_class  = CLS_J;
        req_target = jmp_target;
        if (br_taken) begin
            req_class  = CLS_BR;
            req_target = br_target;
        end else if (jr_valid) begin
            req_class  = CLS_JR;
            req_target = jr_target;
        end else if (!jmp_valid) begin
            req_valid  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            pc_reg          <= RESET_PC;
            pend_target_reg <= 32'h0;
            pend_class_reg  <= CLS_J;
            flush_reg       <= 1'b0;
            err_reg         <= 1'b0;
            cnt_reg         <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            pend_target_reg <= pend_target_next;
            pend_class_reg  <= pend_class_next;
            flush_reg       <= flush_next;
            err_reg         <= err_next;
            cnt_reg         <= cnt_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        pend_target_next = pend_target_reg;
        pend_class_next  = pend_class_reg;
        flush_next       = 1'b0;
        err_next         = 1'b0;
        cnt_next         = cnt_reg;
        apply            = 1'b0;
        apply_target     = req_target;

        case (state_reg)
            IDLE: begin
                if (stall) begin
                    if (req_valid) begin
                        pend_target_next = req_target;
                        pend_class_next  = req_class;
                        state_next       = PEND;
                    end
                end else if (req_valid) begin
                    apply = 1'b1;
                end else begin
                    pc_next = pc_reg + 32'd4;
                end
            end
            PEND: begin
                if (stall) begin
                    // Equal class replaces: the newer request of the same kind is the live one.
                    if (req_valid && (req_class >= pend_class_reg)) begin
                        pend_target_next = req_target;
                        pend_class_next  = req_class;
                    end
                end else begin
                    apply      = 1'b1;
                    state_next = IDLE;
                    if (!(req_valid && (req_class > pend_class_reg))) begin
                        apply_target = pend_target_reg;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (apply) begin
            pc_next    = {apply_target[31:2], 2'b00};
            flush_next = 1'b1;
            err_next   = |apply_target[1:0];
            if (cnt_reg != {CNT_W{1'b1}}) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_comb begin
        pc            = pc_reg;
        pc_plus4      = pc_reg + 32'd4;
        flush_if      = flush_reg;
        addr_err      = err_reg;
        redirect_pend = (state_reg == PEND);
        redirect_cnt  = cnt_reg;
    end

endmodule

// File: tb/tb_pc_redirect_sequencer.sv
// Bench for pc_redirect_sequencer: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a cycle-level behavioural model.
module tb_pc_redirect_sequencer;

    localparam int          CNT_W    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;
    localparam int          NVEC     = 23;
    localparam int          NRAND    = 600;

    logic             clk = 1'b0;
    logic             rst, stall, br_taken, jmp_valid, jr_valid;
    logic [31:0]      br_target, jmp_target, jr_target;
    logic [31:0]      pc, pc_plus4;
    logic             flush_if, redirect_pend, addr_err;
    logic [CNT_W-1:0] redirect_cnt;

    int n_pass  = 0;
    int n_total = 0;

    pc_redirect_sequencer #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .br_taken(br_taken), .br_target(br_target),
        .jmp_valid(jmp_valid), .jmp_target(jmp_target),
        .jr_valid(jr_valid), .jr_target(jr_target),
        .pc(pc), .pc_plus4(pc_plus4), .flush_if(flush_if),
        .redirect_pend(redirect_pend), .addr_err(addr_err),
        .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] brt;
        logic        jv;
        logic [31:0] jt;
        logic        jrv;
        logic [31:0] jrt;
        logic [31:0] e_pc;
        logic        e_flush;
        logic        e_pend;
        logic        e_err;
        int          e_cnt;
    } vec_t;

    vec_t vecs[NVEC];

    function automatic vec_t mk(logic s, logic b, logic [31:0] bt, logic j, logic [31:0] jt,
                                logic r, logic [31:0] rt, logic [31:0] epc, logic ef,
                                logic ep, logic ee, int ec);
        vec_t v;
        v.stall = s; v.br = b; v.brt = bt; v.jv = j; v.jt = jt; v.jrv = r; v.jrt = rt;
        v.e_pc = epc; v.e_flush = ef; v.e_pend = ep; v.e_err = ee; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic check_all(string tag, logic [31:0] e_pc, logic e_flush, logic e_pend,
                             logic e_err, int e_cnt);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".pc_plus4"}, pc_plus4, e_pc + 32'd4);
        chk({tag, ".flush_if"}, {31'b0, flush_if}, {31'b0, e_flush});
        chk({tag, ".redirect_pend"}, {31'b0, redirect_pend}, {31'b0, e_pend});
        chk({tag, ".addr_err"}, {31'b0, addr_err}, {31'b0, e_err});
        chk({tag, ".redirect_cnt"}, 32'(redirect_cnt), 32'(e_cnt));
    endtask

    task automatic drive(logic r, logic s, logic b, logic [31:0] bt, logic j, logic [31:0] jt,
                         logic jr, logic [31:0] jrt);
        rst = r; stall = s; br_taken = b; br_target = bt;
        jmp_valid = j; jmp_target = jt; jr_valid = jr; jr_target = jrt;
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: pending redirect held as an optional (valid, target, class).
    logic [31:0] m_pc;
    logic        m_have;
    logic [31:0] m_ptgt;
    int          m_pcls;
    int          m_cnt;
    logic        m_flush, m_err;

    task automatic model_step(logic r, logic s, logic b, logic [31:0] bt, logic j,
                              logic [31:0] jt, logic jr, logic [31:0] jrt);
        int          cls;
        logic [31:0] tgt;
        logic        use_it;
        logic [31:0] win;
        cls = -1; tgt = 32'h0;
        if (b)       begin cls = 2; tgt = bt;  end
        else if (jr) begin cls = 1; tgt = jrt; end
        else if (j)  begin cls = 0; tgt = jt;  end
        m_flush = 1'b0; m_err = 1'b0;
        if (r) begin
            m_pc = RESET_PC; m_have = 1'b0; m_cnt = 0;
        end else if (s) begin
            if (cls >= 0 && (!m_have || cls >= m_pcls)) begin
                m_have = 1'b1; m_ptgt = tgt; m_pcls = cls;
            end
        end else begin
            use_it = 1'b1; win = tgt;
            if (m_have) begin
                if (!(cls > m_pcls)) win = m_ptgt;
                m_have = 1'b0;
            end else if (cls < 0) begin
                use_it = 1'b0;
            end
            if (use_it) begin
                m_pc = win & 32'hFFFF_FFFC;
                m_flush = 1'b1;
                m_err = (win & 32'h3) != 0;
                if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 0,            0, 0,          0, 0,        32'h4,    0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0,            0, 0,          0, 0,        32'h8,    0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0,            0, 0,          0, 0,        32'hC,    0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0,            0, 0,          0, 0,        32'h10,   0, 0, 0, 0);
        vecs[4]  = mk(0, 1, 32'h40,       0, 0,          0, 0,        32'h40,   1, 0, 0, 1);
        vecs[5]  = mk(0, 0, 0,            0, 0,          0, 0,        32'h44,   0, 0, 0, 1);
        vecs[6]  = mk(0, 1, 32'h80,       1, 32'h200,    0, 0,        32'h80,   1, 0, 0, 2);
        vecs[7]  = mk(0, 0, 0,            0, 0,          0, 0,        32'h84,   0, 0, 0, 2);
        vecs[8]  = mk(1, 0, 0,            1, 32'h100,    0, 0,        32'h84,   0, 1, 0, 2);
        vecs[9]  = mk(1, 0, 0,            0, 0,          0, 0,        32'h84,   0, 1, 0, 2);
        vecs[10] = mk(1, 0, 0,            0, 0,          0, 0,        32'h84,   0, 1, 0, 2);
        vecs[11] = mk(0, 0, 0,            0, 0,          0, 0,        32'h100,  1, 0, 0, 3);
        vecs[12] = mk(1, 0, 0,            1, 32'h100,    0, 0,        32'h100,  0, 1, 0, 3);
        vecs[13] = mk(1, 1, 32'h300,      0, 0,          0, 0,        32'h100,  0, 1, 0, 3);
        vecs[14] = mk(1, 0, 0,            0, 0,          1, 32'h44,   32'h100,  0, 1, 0, 3);
        vecs[15] = mk(0, 0, 0,            0, 0,          0, 0,        32'h300,  1, 0, 0, 4);
        vecs[16] = mk(0, 0, 0,            0, 0,          0, 0,        32'h304,  0, 0, 0, 4);
        vecs[17] = mk(0, 0, 0,            0, 0,          1, 32'h1003, 32'h1000, 1, 0, 1, 5);
        vecs[18] = mk(0, 0, 0,            0, 0,          0, 0,        32'h1004, 0, 0, 0, 5);
        vecs[19] = mk(1, 0, 0,            1, 32'h2002,   0, 0,        32'h1004, 0, 1, 0, 5);
        vecs[20] = mk(0, 0, 0,            0, 0,          1, 32'h3000, 32'h3000, 1, 0, 0, 6);
        vecs[21] = mk(1, 1, 32'h501,      0, 0,          0, 0,        32'h3000, 0, 1, 0, 6);
        vecs[22] = mk(0, 1, 32'h600,      0, 0,          0, 0,        32'h500,  1, 0, 1, 7);

        // Reset for two cycles
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        check_all("reset", RESET_PC, 0, 0, 0, 0);
        $display("reset: pc=%h cnt=%0d", pc, redirect_cnt);

        for (int i = 0; i < NVEC; i++) begin
            drive(0, vecs[i].stall, vecs[i].br, vecs[i].brt, vecs[i].jv, vecs[i].jt,
                  vecs[i].jrv, vecs[i].jrt);
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_flush, vecs[i].e_pend,
                      vecs[i].e_err, vecs[i].e_cnt);
            $display("vec%0d: pc=%h flush=%b pend=%b err=%b cnt=%0d", i, pc, flush_if,
                     redirect_pend, addr_err, redirect_cnt);
        end

        // Top-of-address-space wrap, then reset in the middle of a pending redirect
        drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        check_all("wrap_redirect", 32'hFFFF_FFFC, 1, 0, 0, 8);
        $display("wrap_redirect: pc=%h", pc);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_all("wrap_seq", 32'h0, 0, 0, 0, 8);
        $display("wrap_seq: pc=%h err=%b", pc, addr_err);
        drive(0, 1, 0, 0, 1, 32'h100, 0, 0);
        check_all("pend_before_rst", 32'h0, 0, 1, 0, 8);
        $display("pend_before_rst: pend=%b", redirect_pend);
        drive(1, 0, 1, 32'h40, 0, 0, 0, 0);
        check_all("rst_in_pend", RESET_PC, 0, 0, 0, 0);
        $display("rst_in_pend: pc=%h pend=%b cnt=%0d", pc, redirect_pend, redirect_cnt);

        // Randomized traffic against the reference model
        m_pc = RESET_PC; m_have = 1'b0; m_ptgt = 32'h0; m_pcls = 0; m_cnt = 0;
        m_flush = 1'b0; m_err = 1'b0;
        for (int n = 0; n < NRAND; n++) begin
            logic        r, s, b, j, jr;
            logic [31:0] bt, jt, jrt;
            r  = ($urandom_range(199) == 0);
            s  = ($urandom_range(99) < 35);
            b  = ($urandom_range(99) < 20);
            j  = ($urandom_range(99) < 20);
            jr = ($urandom_range(99) < 15);
            bt = $urandom; jt = $urandom; jrt = $urandom;
            if ($urandom_range(3) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(3) != 0) jt[1:0] = 2'b00;
            if ($urandom_range(3) != 0) jrt[1:0] = 2'b00;
            drive(r, s, b, bt, j, jt, jr, jrt);
            model_step(r, s, b, bt, j, jt, jr, jrt);
            check_all($sformatf("rand%0d", n), m_pc, m_flush, m_have, m_err, m_cnt);
            $display("rand%0d: rst=%b stall=%b br=%b jr=%b j=%b pc=%h flush=%b pend=%b err=%b cnt=%0d",
                     n, r, s, b, jr, j, pc, flush_if, redirect_pend, addr_err, redirect_cnt);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
